// File: rtl/crypto_wallet_mem_pkg.sv
// Shared constants and FSM encoding for the on-chip wallet RAM arbiter.
package crypto_wallet_mem_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int DEPTH  = 6500;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WIPE = 1'b1
    } state_e;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(DEPTH);
    endfunction

endpackage

// File: rtl/crypto_wallet_onchip_mem_arbiter_if.sv
// Avalon-MM-style requester bus: master drives the request, slave answers.
interface crypto_wallet_onchip_mem_arbiter_if;
    import crypto_wallet_mem_pkg::*;

    // A request is accepted in a cycle where (read | write) & ~waitrequest;
    // the master holds all request fields stable until then.
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/crypto_wallet_rr_arb2.sv
// Two-way round-robin grant; ties go to the requester not granted most recently.
module crypto_wallet_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // prio_q = 0 favours requester 0 on a tie
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end
        if (gnt_o[0]) begin
            prio_d = 1'b1;
        end else if (gnt_o[1]) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/crypto_wallet_onchip_mem_arbiter.sv
// Shares one single-port wallet RAM between two requesters and adds a zeroize sequencer.
module crypto_wallet_onchip_mem_arbiter
    import crypto_wallet_mem_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    crypto_wallet_onchip_mem_arbiter_if.slave m0,
    crypto_wallet_onchip_mem_arbiter_if.slave m1,
    input  logic                wipe_req,
    output logic                wipe_busy,
    output logic                wipe_done,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [BE_W-1:0]     mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata,
    output state_e              dbg_state_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [1:0]        rdv_q, rdv_d;
    logic              oor_q, oor_d;

    logic              arb_en;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              cs_raw;
    logic              wr_raw;

    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_write;
    logic              sel_in_range;

    assign req = {m1.read | m1.write, m0.read | m0.write};

    crypto_wallet_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en_i  (arb_en),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign sel_addr     = gnt[1] ? m1.address    : m0.address;
    assign sel_be       = gnt[1] ? m1.byteenable : m0.byteenable;
    assign sel_wdata    = gnt[1] ? m1.writedata  : m0.writedata;
    assign sel_write    = gnt[1] ? m1.write      : m0.write;
    assign sel_in_range = addr_in_range(sel_addr);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        done_d         = 1'b0;
        rdv_d          = 2'b00;
        oor_d          = 1'b0;
        arb_en         = 1'b0;
        cs_raw         = 1'b0;
        wr_raw         = 1'b0;
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;

        case (state_q)
            IDLE: begin
                arb_en = ~reset;
                if (|gnt) begin
                    mem_address    = sel_addr;
                    mem_byteenable = sel_be;
                    mem_writedata  = sel_wdata;
                    // Out-of-range accesses are still granted but never reach the RAM.
                    cs_raw         = sel_in_range;
                    wr_raw         = sel_write & sel_in_range;
                    oor_d          = ~sel_in_range;
                end
                rdv_d[0] = gnt[0] & m0.read & ~m0.write;
                rdv_d[1] = gnt[1] & m1.read & ~m1.write;
                if (wipe_req) begin
                    state_d = WIPE;
                end
            end
            WIPE: begin
                mem_address    = cnt_q;
                mem_byteenable = '1;
                mem_writedata  = '0;
                cs_raw         = 1'b1;
                wr_raw         = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            rdv_q   <= 2'b00;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            rdv_q   <= rdv_d;
            oor_q   <= oor_d;
        end
    end

    assign mem_chipselect = cs_raw & ~reset;
    assign mem_write      = wr_raw & ~reset;

    assign m0.waitrequest   = req[0] & ~gnt[0];
    assign m1.waitrequest   = req[1] & ~gnt[1];
    assign m0.readdata      = oor_q ? '0 : mem_readdata;
    assign m1.readdata      = oor_q ? '0 : mem_readdata;
    assign m0.readdatavalid = rdv_q[0];
    assign m1.readdatavalid = rdv_q[1];

    assign wipe_busy   = (state_q == WIPE);
    assign wipe_done   = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crypto_wallet_onchip_mem_arbiter.sv
// Directed bench for the wallet RAM arbiter: behavioural RAM, read scoreboard, summary.
module tb_crypto_wallet_onchip_mem_arbiter;
    import crypto_wallet_mem_pkg::*;

    logic              clk;
    logic              reset;
    logic              wipe_req;
    logic              wipe_busy;
    logic              wipe_done;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    state_e            dbg_state;

    crypto_wallet_onchip_mem_arbiter_if m0_if ();
    crypto_wallet_onchip_mem_arbiter_if m1_if ();

    crypto_wallet_onchip_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_if),
        .m1             (m1_if),
        .wipe_req       (wipe_req),
        .wipe_busy      (wipe_busy),
        .wipe_done      (wipe_done),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .dbg_state_o    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    // ---------------- behavioural RAM: registered address, unregistered q ----------------
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    logic [ADDR_W-1:0] ram_addr_q = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'hA5A5_A5A5;
    end

    always @(posedge clk) begin
        if (mem_chipselect && (int'(mem_address) < DEPTH)) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
                end
            end
            ram_addr_q <= mem_address;
        end
    end

    assign mem_readdata = ram[ram_addr_q];

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard: each accepted read expects a valid one cycle later ----------------
    typedef struct {
        bit          m;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;

    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            sb_e = exp_q.pop_front();
            if (sb_e.m) begin
                check_vec("m1_rdv", 32'(m1_if.readdatavalid), 32'd1);
                check_vec("m1_rdata", m1_if.readdata, sb_e.data);
                check_vec("m0_rdv_quiet", 32'(m0_if.readdatavalid), 32'd0);
            end else begin
                check_vec("m0_rdv", 32'(m0_if.readdatavalid), 32'd1);
                check_vec("m0_rdata", m0_if.readdata, sb_e.data);
                check_vec("m1_rdv_quiet", 32'(m1_if.readdatavalid), 32'd0);
            end
        end else if (m0_if.readdatavalid || m1_if.readdatavalid) begin
            check_vec("unexpected_rdv", {30'd0, m1_if.readdatavalid, m0_if.readdatavalid}, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input bit m, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                           input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        if (m) begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.byteenable = be; m1_if.writedata = d;
        end else begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.byteenable = be; m0_if.writedata = d;
        end
    endtask

    function automatic logic get_wait(input bit m);
        return m ? m1_if.waitrequest : m0_if.waitrequest;
    endfunction

    // One access on master m; holds the request until accepted (bounded), then releases it.
    task automatic do_access(input bit m, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                             input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wd,
                             input logic [DATA_W-1:0] exp_rd, input logic exp_cs,
                             input int max_wait, input string tag);
        int waited;
        @(negedge clk);
        set_req(m, rd, wr, a, be, wd);
        waited = 0;
        #1;
        while (get_wait(m) && waited < max_wait) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (get_wait(m)) begin
            check_vec({tag, "_accept"}, 32'(get_wait(m)), 32'd0);
        end else begin
            check_vec({tag, "_cs"}, 32'(mem_chipselect), 32'(exp_cs));
            if (rd && !wr) exp_q.push_back('{m, exp_rd, cyc + 1});
        end
        @(negedge clk);
        set_req(m, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wr_word(input bit m, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        do_access(m, 1'b0, 1'b1, a, 4'hF, d, 32'h0, 1'b1, 0, "preload");
    endtask

    // ---------------- stimulus ----------------
    logic [ADDR_W-1:0] a0 [3] = '{13'd10, 13'd11, 13'd12};
    logic [ADDR_W-1:0] a1 [2] = '{13'd20, 13'd21};
    logic [DATA_W-1:0] d0 [3] = '{32'h0A0A_0010, 32'h0A0A_0011, 32'h0A0A_0012};
    logic [DATA_W-1:0] d1 [2] = '{32'h0B0B_0020, 32'h0B0B_0021};
    bit                g_exp [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        int i0, i1, busy_n, done_n, addr_err;

        reset    = 1'b1;
        wipe_req = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 13'd1, 4'hF, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        #1;
        check_vec("rst_wait0", 32'(m0_if.waitrequest), 32'd1);
        check_vec("rst_cs", 32'(mem_chipselect), 32'd0);
        check_vec("rst_busy", 32'(wipe_busy), 32'd0);
        check_vec("rst_done", 32'(wipe_done), 32'd0);
        check_vec("rst_rdv0", 32'(m0_if.readdatavalid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);

        // single write then read, no stall allowed
        do_access(1'b0, 1'b0, 1'b1, 13'd5, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1, 0, "t1_wr");
        do_access(1'b0, 1'b1, 1'b0, 13'd5, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1, 0, "t1_rd");

        // byte-enable merge
        do_access(1'b0, 1'b0, 1'b1, 13'd7, 4'hF, 32'h1122_3344, 32'h0, 1'b1, 0, "be_wr1");
        do_access(1'b0, 1'b0, 1'b1, 13'd7, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b1, 0, "be_wr2");
        do_access(1'b0, 1'b1, 1'b0, 13'd7, 4'hF, 32'h0, 32'h11BB_33DD, 1'b1, 0, "be_rd");

        // read+write together acts as a write and yields no valid
        do_access(1'b0, 1'b1, 1'b1, 13'd8, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b1, 0, "rw_both");
        do_access(1'b0, 1'b1, 1'b0, 13'd8, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b1, 0, "rw_rd");

        // out of range on m1
        do_access(1'b1, 1'b0, 1'b1, 13'd6500, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 0, "oor_wr");
        do_access(1'b1, 1'b1, 1'b0, 13'd6500, 4'hF, 32'h0, 32'h0, 1'b0, 0, "oor_rd");
        do_access(1'b0, 1'b1, 1'b0, 13'd6499, 4'hF, 32'h0, 32'hA5A5_A5A5, 1'b1, 0, "edge_rd");

        // contention; m1 is granted last so m0 wins the first tie
        for (int i = 0; i < 3; i++) wr_word(1'b0, a0[i], d0[i]);
        for (int i = 0; i < 2; i++) wr_word(1'b1, a1[i], d1[i]);
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            set_req(1'b0, i0 < 3, 1'b0, a0[(i0 < 3) ? i0 : 0], 4'hF, '0);
            set_req(1'b1, i1 < 2, 1'b0, a1[(i1 < 2) ? i1 : 0], 4'hF, '0);
            #1;
            check_vec($sformatf("cont_wait0_c%0d", c), 32'(m0_if.waitrequest), 32'((i0 < 3) && g_exp[c] != 1'b0));
            check_vec($sformatf("cont_wait1_c%0d", c), 32'(m1_if.waitrequest), 32'((i1 < 2) && g_exp[c] != 1'b1));
            if (!g_exp[c] && i0 < 3) begin
                exp_q.push_back('{1'b0, d0[i0], cyc + 1});
                i0++;
            end else if (g_exp[c] && i1 < 2) begin
                exp_q.push_back('{1'b1, d1[i1], cyc + 1});
                i1++;
            end
        end
        @(negedge clk);
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0, '0);

        // zeroize; a read granted alongside wipe_req returns data in the first WIPE cycle
        wr_word(1'b0, 13'd0, 32'h0000_0F00);
        wr_word(1'b0, 13'd3000, 32'h3000_3000);
        wr_word(1'b0, 13'd6499, 32'h6499_6499);
        @(negedge clk);
        wipe_req = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 13'd3000, 4'hF, '0);
        #1;
        check_vec("prewipe_wait0", 32'(m0_if.waitrequest), 32'd0);
        exp_q.push_back('{1'b0, 32'h3000_3000, cyc + 1});
        @(negedge clk);
        wipe_req = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        busy_n   = 0;
        done_n   = 0;
        addr_err = 0;
        fork
            begin
                for (int i = 0; i < 6510; i++) begin
                    #1;
                    if (wipe_busy) begin
                        if (mem_address != ADDR_W'(busy_n) || !mem_chipselect || !mem_write ||
                            mem_writedata != 32'h0 || mem_byteenable != 4'hF) addr_err++;
                        busy_n++;
                    end
                    if (wipe_done) begin
                        done_n++;
                        check_vec("stall_grant_at_done", 32'(m0_if.waitrequest), 32'd0);
                    end
                    @(negedge clk);
                end
            end
            begin
                repeat (10) @(negedge clk);
                do_access(1'b0, 1'b1, 1'b0, 13'd3000, 4'hF, '0, 32'h0, 1'b1, 7000, "wipe_stall");
            end
        join
        check_vec("wipe_busy_cycles", 32'(busy_n), 32'd6500);
        check_vec("wipe_done_pulses", 32'(done_n), 32'd1);
        check_vec("wipe_seq_errors", 32'(addr_err), 32'd0);
        do_access(1'b0, 1'b1, 1'b0, 13'd0, 4'hF, '0, 32'h0, 1'b1, 0, "wiped0");
        do_access(1'b1, 1'b1, 1'b0, 13'd6499, 4'hF, '0, 32'h0, 1'b1, 0, "wiped6499");

        // reset in the middle of a wipe
        wr_word(1'b0, 13'd50, 32'h5050_5050);
        wr_word(1'b0, 13'd200, 32'h2000_0200);
        @(negedge clk);
        wipe_req = 1'b1;
        @(negedge clk);
        wipe_req = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check_vec("midwipe_addr", 32'(mem_address), 32'd100);
        reset = 1'b1;
        #1;
        check_vec("midwipe_rst_cs", 32'(mem_chipselect), 32'd0);
        @(negedge clk);
        #1;
        check_vec("midwipe_busy", 32'(wipe_busy), 32'd0);
        reset = 1'b0;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (wipe_done) done_n++;
            @(negedge clk);
        end
        check_vec("midwipe_no_done", 32'(done_n), 32'd0);
        do_access(1'b0, 1'b1, 1'b0, 13'd50, 4'hF, '0, 32'h0, 1'b1, 0, "midwipe_rd50");
        do_access(1'b0, 1'b1, 1'b0, 13'd200, 4'hF, '0, 32'h2000_0200, 1'b1, 0, "midwipe_rd200");

        repeat (3) @(negedge clk);
        check_vec("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/crypto_wallet_onchip_mem_arbiter.md
Name: crypto_wallet_onchip_mem_arbiter

Overview:
- Shares the single-port 32-bit on-chip RAM (6500 words, 13-bit word address, byte enables, registered address, unregistered q) between two Avalon-MM-style requesters.
- Round-robin arbitration, with waitrequest back-pressure and readdatavalid at fixed one-cycle latency.
- Adds a zeroize sequencer that writes 32'h0 to every word on request; used to wipe key material.
- Sits between the system interconnect masters and the RAM instance.

Parameters:
- ADDR_W, 13, word address width
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- DEPTH, 6500, number of implemented words; addresses >= DEPTH are out of range

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- mN_address  in  ADDR_W  requester N address (N = 0, 1; same set for both)
- mN_byteenable  in  BE_W  requester N byte enables
- mN_read  in  1  requester N read request
- mN_write  in  1  requester N write request
- mN_writedata  in  DATA_W  requester N write data
- mN_waitrequest  out  1  request not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  mN_readdata valid this cycle
- wipe_req  in  1  start zeroize (level sampled each cycle)
- wipe_busy  out  1  zeroize in progress
- wipe_done  out  1  one-cycle pulse when zeroize completes
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_readdata  in  DATA_W  from RAM readdata (valid the cycle after the address)

Behaviour:
- Reset values:
  - FSM = IDLE; round-robin pointer favours m0.
  - wipe_busy, wipe_done, both readdatavalid = 0; wipe counter = 0.
  - While reset is high, waitrequest = 1 for any asserted request and mem_chipselect = 0.
- FSM states:
  - IDLE: arbitration active.
  - WIPE: sequencer owns the RAM.
- IDLE, arbitration:
  - reqN = mN_read | mN_write.
  - One requester only: it is granted.
  - Both requesting: the one not granted most recently wins. The pointer updates only on a grant.
  - Grants are combinational in the same cycle. mN_waitrequest = reqN & ~grantN. A master holds its request stable until waitrequest is low.
- Granted access:
  - Drive mem_address, mem_byteenable and mem_writedata from the granted master.
  - mem_chipselect = 1 and mem_write = the master's write.
- Read and write asserted together: treated as a write. No readdatavalid is produced.
- Read latency:
  - A read granted in cycle t raises mN_readdatavalid in cycle t+1, with mN_readdata = mem_readdata.
  - Back-to-back reads by one master are allowed every cycle.
  - mN_readdata for the non-reading master is don't-care; the bench checks only under valid.
- Out-of-range address (>= DEPTH):
  - The access is granted, but mem_chipselect = 0.
  - A write is dropped.
  - A read returns 32'h0 with readdatavalid at t+1, via a registered out-of-range flag.
- Zeroize sequencing:
  - wipe_req high in IDLE transitions to WIPE on the next edge. Arbitration still runs in the cycle wipe_req is high.
  - In WIPE, all requests see waitrequest = 1.
  - The sequencer drives mem_chipselect = 1, mem_write = 1, mem_byteenable = all ones, mem_writedata = 0, and mem_address = counter.
  - The counter runs 0 to DEPTH-1, one word per cycle: DEPTH cycles total.
  - wipe_busy = 1 throughout WIPE.
  - On the cycle after the DEPTH-1 write, wipe_done pulses for one cycle, the state returns to IDLE and the counter clears.
  - A read granted in the cycle before WIPE still delivers readdatavalid in the first WIPE cycle.
- wipe_req while already in WIPE: ignored; no restart or extension.
- wipe_req held high continuously: a new wipe starts one cycle after wipe_done (IDLE for one cycle, during which arbitration proceeds).
- Reset mid-wipe: returns to IDLE with no wipe_done. Memory is partially cleared; software re-issues the wipe.

Decomposition:
- Shared package crypto_wallet_mem_pkg holds:
  - ADDR_W, DATA_W, BE_W, DEPTH constants
  - state enum {IDLE, WIPE}
- One natural sub-module: crypto_wallet_rr_arb2, a two-way round-robin grant with pointer register.
- Wipe counter, muxing and read-valid tracking stay in the top module.

Test Plan:
- Single read: m0 writes 32'hDEADBEEF to addr 5 with be=4'hF, then reads addr 5 → waitrequest 0 both cycles; m0_readdatavalid=1 one cycle after the read, data 32'hDEADBEEF.
- Contention: m0 and m1 both hold reads for 4 cycles → grants alternate m0, m1, m0, m1. Each loser sees waitrequest=1. Each valid arrives exactly 1 cycle after its grant.
- Byte enables: write 32'h11223344 be=4'hF to addr 7, then 32'hAABBCCDD be=4'b0101 → readback 32'h11BB33DD.
- Out-of-range: m1 writes 32'h12345678 to addr 6500, then reads addr 6500 → mem_chipselect=0 both times; read returns 32'h0 with valid.
- Zeroize: preload addr 0, 3000 and 6499 with nonzero data; pulse wipe_req → wipe_busy for 6500 cycles; m0 read during wipe stalls; wipe_done pulses once; all three addresses read 0; the stalled read completes afterwards.
- Reset mid-wipe: assert reset at counter=100 → wipe_busy=0 next cycle, no wipe_done; addr 50 reads 0, addr 200 keeps its preload.
